// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: one write per rising edge of i_rx_valid,
// registered read port, count/empty/full status and sticky overflow.
// Optional: define UART_RX_FIFO_ERR_COUNT_EN to add an 8-bit saturating error counter.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [8:0]    i_rx_parallel,
    input  logic          i_rx_valid,
    input  logic          i_rx_error,
    input  logic          i_rd_en,
    input  logic          i_clr_flags,
    output logic [8:0]    o_rd_data,
    output logic          o_rd_valid,
    output logic          o_empty,
    output logic          o_full,
    output logic [AW:0]   o_count,
    output logic          o_overflow
`ifdef UART_RX_FIFO_ERR_COUNT_EN
    ,
    output logic [7:0]    o_err_count
`endif
);

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          r_valid_d;
    logic          wr_req, rd_acc, wr_acc, drop;

    assign o_empty = (o_count == '0);
    assign o_full  = (o_count == (AW+1)'(DEPTH));

    assign wr_req = i_rx_valid & ~r_valid_d;
    assign rd_acc = i_rd_en & ~o_empty;
    // At full a same-cycle read frees the slot, so the write still lands.
    assign wr_acc = wr_req & (~o_full | rd_acc);
    assign drop   = wr_req & o_full & ~rd_acc;

    always_ff @(posedge i_clk) begin
        if (wr_acc)
            mem[wr_ptr] <= i_rx_parallel;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid_d  <= 1'b1;   // a level already high across reset is not a new word
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            r_valid_d  <= i_rx_valid;
            o_rd_valid <= rd_acc;
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                o_rd_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc)
                o_count <= o_count + 1'b1;
            else if (rd_acc && !wr_acc)
                o_count <= o_count - 1'b1;
            if (drop)
                o_overflow <= 1'b1;
            else if (i_clr_flags)
                o_overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_ERR_COUNT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            o_err_count <= '0;
        else if (i_clr_flags)
            o_err_count <= {7'd0, i_rx_error};
        else if (i_rx_error && o_err_count != 8'hFF)
            o_err_count <= o_err_count + 1'b1;
    end
`else
    logic unused_rx_error;
    assign unused_rx_error = i_rx_error;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a cycle model tracks queue contents and flags,
// a negedge monitor compares every status output and each popped word.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [8:0]    rx_parallel = '0;
    logic          rx_valid = 1'b0;
    logic          rx_error = 1'b0;
    logic          rd_en = 1'b0;
    logic          clr_flags = 1'b0;
    logic [8:0]    rd_data;
    logic          rd_valid, empty, full, overflow;
    logic [AW:0]   count;
`ifdef UART_RX_FIFO_ERR_COUNT_EN
    logic [7:0]    err_count;
`endif

    int errors = 0;
    int checks = 0;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_parallel(rx_parallel),
        .i_rx_valid(rx_valid), .i_rx_error(rx_error), .i_rd_en(rd_en),
        .i_clr_flags(clr_flags), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
        .o_empty(empty), .o_full(full), .o_count(count), .o_overflow(overflow)
`ifdef UART_RX_FIFO_ERR_COUNT_EN
        , .o_err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: scoreboard queue of stored words plus flag state.
    logic [8:0] sb [$];
    logic [8:0] m_data = '0;
    logic       m_vd = 1'b1, m_ovf = 1'b0, m_rv = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_data = '0; m_vd = 1'b1; m_ovf = 1'b0; m_rv = 1'b0;
        end else begin
            automatic bit wr = rx_valid && !m_vd;
            automatic int sz = sb.size();
            automatic bit ra = rd_en && (sz != 0);
            if (ra) m_data = sb.pop_front();
            if (wr && (sz < DEPTH || ra)) sb.push_back(rx_parallel);
            if (wr && sz == DEPTH && !ra) m_ovf = 1'b1;
            else if (clr_flags) m_ovf = 1'b0;
            m_vd = rx_valid;
            m_rv = ra;
        end
    end

    always @(negedge clk) begin
        chk("count",    32'(count),    32'(sb.size()));
        chk("empty",    32'(empty),    32'(sb.size() == 0));
        chk("full",     32'(full),     32'(sb.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("rd_valid", 32'(rd_valid), 32'(m_rv));
        chk("rd_data",  32'(rd_data),  32'(m_data));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [8:0] d, input int hold);
        rx_parallel = d; rx_valid = 1'b1;
        tick(hold);
        rx_valid = 1'b0;
        tick(1);
    endtask

    task automatic drain(input int n);
        rd_en = 1'b1;
        tick(n);
        rd_en = 1'b0;
        tick(2);
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("reset_count", 32'(count), 0);
        chk("reset_empty", 32'(empty), 1);

        // single word held for 20 cycles is captured once
        send(9'h0A5, 20);
        chk("single_count", 32'(count), 1);
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
        chk("single_data", 32'(rd_data), 32'h0A5);
        chk("single_empty", 32'(empty), 1);
        tick(2);

        // fill, overflow, drain
        for (int i = 0; i < 16; i++) send(9'(9'h100 + i), 1);
        send(9'h1FF, 1);
        chk("fill_full", 32'(full), 1);
        chk("fill_ovf",  32'(overflow), 1);
        drain(16);
        clr_flags = 1'b1; tick(1); clr_flags = 1'b0; tick(1);
        chk("ovf_cleared", 32'(overflow), 0);

        // simultaneous write and read at full
        for (int i = 0; i < 16; i++) send(9'(9'h120 + i), 1);
        rx_parallel = 9'h1AA; rx_valid = 1'b1; rd_en = 1'b1;
        tick(1);
        rx_valid = 1'b0; rd_en = 1'b0;
        tick(1);
        chk("simul_count", 32'(count), 16);
        chk("simul_ovf",   32'(overflow), 0);
        drain(16);

        // empty boundary
        rd_en = 1'b1; tick(1); rd_en = 1'b0; tick(1);
        rx_parallel = 9'h055; rx_valid = 1'b1; rd_en = 1'b1;
        tick(1);
        rx_valid = 1'b0; rd_en = 1'b0;
        chk("empty_wr_rd_count", 32'(count), 1);
        drain(2);

        // streaming across pointer wrap
        for (int i = 0; i < 40; i++) begin
            rx_parallel = 9'((i * 7 + 3) & 9'h1FF); rx_valid = 1'b1;
            rd_en = (i % 3) != 0;
            tick(1);
            rx_valid = 1'b0; rd_en = 1'b0;
            tick(1);
        end
        drain(20);

        // reset mid-operation
        for (int i = 0; i < 5; i++) send(9'(9'h080 + i), 1);
        rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
        chk("midreset_count", 32'(count), 0);
        chk("midreset_empty", 32'(empty), 1);

        // valid held high across reset is not captured
        rx_parallel = 9'h133; rx_valid = 1'b1; tick(1);
        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(5);
        rx_valid = 1'b0; tick(1);
        chk("held_valid_count", 32'(count), 0);

`ifdef UART_RX_FIFO_ERR_COUNT_EN
        for (int i = 0; i < 300; i++) begin
            rx_error = 1'b1; tick(1); rx_error = 1'b0; tick(1);
        end
        chk("err_sat", 32'(err_count), 255);
        chk("err_no_write", 32'(count), 0);
        clr_flags = 1'b1; tick(1); clr_flags = 1'b0; tick(1);
        chk("err_clr", 32'(err_count), 0);
        rx_error = 1'b1; clr_flags = 1'b1; tick(1);
        rx_error = 1'b0; clr_flags = 1'b0; tick(1);
        chk("err_clr_inc", 32'(err_count), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver and absorbs its parallel output so the consumer can drain words at its own pace. It turns the receiver's level-style valid flag into one write per received word, stores up to `DEPTH` 9-bit words, and exposes a registered read port with empty/full/count status and a sticky overflow flag. It runs on the same clock as the receiver and requires no clock-domain crossing.

## Interface
- `DEPTH`, default 16: number of stored words; must be a power of two, minimum 2.
- `AW`, default 4: pointer width; must equal log2(`DEPTH`).
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  synchronous, active-low reset, sampled on `i_clk`.
- `i_rx_parallel`  in  9  received word from the receiver; bits above the configured word size are 0.
- `i_rx_valid`  in  1  receiver valid flag; held high after a word completes and cleared at the next start bit. A rising edge marks one new word.
- `i_rx_error`  in  1  receiver error pulse for a framing or parity error; one cycle wide.
- `i_rd_en`  in  1  read request from the consumer.
- `i_clr_flags`  in  1  clears the sticky flags.
- `o_rd_data`  out  9  word popped by the last accepted read.
- `o_rd_valid`  out  1  one-cycle pulse; `o_rd_data` is valid while it is high.
- `o_empty`  out  1  FIFO holds 0 words.
- `o_full`  out  1  FIFO holds `DEPTH` words.
- `o_count`  out  `AW`+1  number of stored words, 0..`DEPTH`.
- `o_overflow`  out  1  sticky; set when a word was dropped because the FIFO was full.

## Operation
- **Edge detect.**
  - `r_valid_d` is a registered copy of `i_rx_valid`.
  - `wr_req = i_rx_valid & ~r_valid_d`.
  - Exactly one write request is generated per high level of `i_rx_valid`, however long the level lasts.
- **Write.**
  - Condition: `wr_req`, and either the FIFO is not full or a read is accepted in the same cycle.
  - Action: `mem[wr_ptr] <= i_rx_parallel`, then `wr_ptr` increments.
- **Read.**
  - An accepted read requires `i_rd_en & ~o_empty`.
  - Action: `o_rd_data <= mem[rd_ptr]`, `rd_ptr` increments, and `o_rd_valid` is 1 on the next cycle.
  - `i_rd_en` while empty is ignored: `o_rd_valid` stays 0 and `o_rd_data` holds its value.
- **Pointers.** Both are `AW` bits wide and wrap modulo `DEPTH` with no special case.
- **Count.** `o_count` is a registered `AW`+1-bit counter:
  - +1 on a write alone.
  - −1 on a read alone.
  - Unchanged on a simultaneous write and read.
- **Flags.** `o_empty = (o_count == 0)` and `o_full = (o_count == DEPTH)`, both combinational from `o_count`.
- **Boundary conditions.**
  - Full, with `wr_req` and no read: the word is dropped, `o_overflow` is set, and pointers and count are unchanged.
  - Full, with `wr_req` and a read: both are accepted and the count stays at `DEPTH`.
  - Empty, with `wr_req` and `i_rd_en`: the write is accepted and the read is ignored, because there is no fall-through. `o_count` becomes 1.
  - `i_clr_flags` together with a new overflow event: set wins.
  - `i_rx_error` does not write anything into the FIFO.
- **Reset values.** Pointers 0; `o_count` 0; `o_empty` 1; `o_full` 0; `o_rd_data` 0; `o_rd_valid` 0; `o_overflow` 0.
  - `r_valid_d` resets to 1, so a valid level already high across reset is not captured again.
  - Memory contents are not reset.
- **Reset mid-operation.** Reset discards all stored words immediately, on the edge where `i_rst_n` is sampled low.

## Timing
- Write latency: `wr_req` in cycle N → `o_count`/`o_empty` update in cycle N+1. The earliest read accept is in cycle N+1.
- Read latency: read accepted in cycle N → `o_rd_data` and `o_rd_valid` in cycle N+1.
- Throughput: one read per cycle and one write per cycle, simultaneously.
- `o_rd_valid` is never high for two cycles unless reads are accepted on consecutive cycles.

## Configuration
- Macro: `UART_RX_FIFO_ERR_COUNT_EN`.
- **Defined:** adds output `o_err_count`, 8 bits.
  - It is a saturating counter of `i_rx_error` pulses and holds at 255.
  - It resets to 0 and is cleared by `i_clr_flags`.
  - An increment coinciding with `i_clr_flags` leaves the counter at 1.
- **Undefined:** the port and the counter are absent. `i_rx_error` is unused, and all other behaviour is identical.

## Test plan
- **Single word:** after reset, raise `i_rx_valid` with `i_rx_parallel=0x0A5` and hold it for 20 cycles → `o_count=1` exactly once. Then pulse `i_rd_en` → `o_rd_valid` one cycle later with `o_rd_data=0x0A5`, and `o_empty=1`.
- **Fill and overflow:** deliver 16 words 0x100..0x10F, then 0x1FF → `o_full=1`, `o_overflow=1`, `o_count=16`. Drain all → data is 0x100..0x10F in order and 0x1FF never appears.
- **Simultaneous at full:** with the FIFO full, assert `wr_req` and `i_rd_en` in the same cycle → `o_count` stays 16, no overflow, and the new word is read last.
- **Empty boundary and wrap:**
  - Issue `i_rd_en` while empty → no `o_rd_valid`.
  - Issue `wr_req` and `i_rd_en` together while empty → `o_count=1`.
  - Stream 40 words with interleaved reads → order is preserved across pointer wrap.
- **Reset:**
  - Assert `i_rst_n=0` with 5 words stored → `o_count=0`, `o_empty=1`.
  - Keep `i_rx_valid` high across reset → no capture afterwards.
- **Error counter:** with `UART_RX_FIFO_ERR_COUNT_EN` defined, send 300 `i_rx_error` pulses → `o_err_count=255`. Pulse `i_clr_flags` → 0.
